// File: rtl/puf_array_seq.sv
// PUF array controller: serially loaded challenge, per-PUF reset gating and
// majority-voted response collection over RESP_BITS rotated challenges.
module puf_array_seq #(
    parameter int N_PUF     = 4,
    parameter int SEL_W     = 2,
    parameter int CHAL_BITS = 128,
    parameter int RESP_BITS = 32,
    parameter int VOTES     = 3,
    parameter int RST_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 si,
    input  logic                 si_en,
    output logic                 so,
    input  logic                 start,
    input  logic [SEL_W-1:0]     puf_sel,
    input  logic [1:0]           length_in,
    input  logic [7:0]           settle,
    output logic [CHAL_BITS-1:0] chal,
    output logic [1:0]           length,
    output logic [N_PUF-1:0]     puf_reset,
    input  logic [N_PUF-1:0]     puf_out,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    output logic                 sel_err
);

    localparam int VC_W  = $clog2(VOTES + 1);
    localparam int BC_W  = $clog2(RESP_BITS + 1);
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam int CYC_W = (RC_W > 8) ? RC_W : 8;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        EVAL,
        SAMP,
        NEXT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel_q;
    logic [7:0]         settle_q;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [VC_W-1:0]    ones;
    logic [VC_W-1:0]    vote_cnt;
    logic [BC_W-1:0]    bit_cnt;
    logic               raw_bit;
    logic               sync_p0;
    logic               sync_p1;
    logic               sel_ok;
    logic               rst_last;
    logic               eval_last;
    logic               vote_last;
    logic               bit_last;
    logic               vote_bit;

    assign sel_ok    = (32'(puf_sel) < N_PUF);
    assign rst_last  = (cyc_cnt == CYC_W'(RST_CYC - 1));
    assign eval_last = (cyc_cnt == (CYC_W'(settle_q) - CYC_W'(1)));
    assign vote_last = (vote_cnt == VC_W'(VOTES - 1));
    assign bit_last  = (bit_cnt == BC_W'(RESP_BITS - 1));
    assign vote_bit  = (ones > VC_W'(VOTES / 2));

    assign so   = chal[CHAL_BITS-1];
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Selected PUF output; sel_q never exceeds N_PUF-1 once latched
    always_comb begin
        raw_bit = 1'b0;
        for (int i = 0; i < N_PUF; i++) begin
            if (sel_q == SEL_W'(i)) raw_bit = puf_out[i];
        end
    end

    // Only the selected PUF is released, and only while it settles and is sampled
    always_comb begin
        puf_reset = '1;
        if (state == EVAL || state == SAMP) begin
            for (int i = 0; i < N_PUF; i++) begin
                if (sel_q == SEL_W'(i)) puf_reset[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw_bit;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && sel_ok) state_nxt = RST;
            RST:  if (rst_last) state_nxt = EVAL;
            EVAL: if (eval_last) state_nxt = SAMP;
            SAMP: state_nxt = vote_last ? NEXT : RST;
            NEXT: state_nxt = bit_last ? DONE : RST;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chal       <= '0;
            length     <= '0;
            sel_q      <= '0;
            settle_q   <= 8'd1;
            cyc_cnt    <= '0;
            ones       <= '0;
            vote_cnt   <= '0;
            bit_cnt    <= '0;
            resp       <= '0;
            resp_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_cnt  <= '0;
                    ones     <= '0;
                    vote_cnt <= '0;
                    bit_cnt  <= '0;
                    if (si_en) chal <= {chal[CHAL_BITS-2:0], si};
                    if (start) begin
                        if (sel_ok) begin
                            sel_q      <= puf_sel;
                            length     <= length_in;
                            settle_q   <= (settle == 8'd0) ? 8'd1 : settle;
                            resp       <= '0;
                            resp_valid <= 1'b0;
                            sel_err    <= 1'b0;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                RST:  cyc_cnt <= rst_last ? '0 : cyc_cnt + CYC_W'(1);
                EVAL: cyc_cnt <= eval_last ? '0 : cyc_cnt + CYC_W'(1);
                SAMP: begin
                    ones     <= ones + VC_W'(sync_p1);
                    vote_cnt <= vote_cnt + VC_W'(1);
                end
                NEXT: begin
                    resp     <= (resp << 1) | RESP_BITS'(vote_bit);
                    chal     <= {chal[CHAL_BITS-2:0], chal[CHAL_BITS-1]};
                    ones     <= '0;
                    vote_cnt <= '0;
                    bit_cnt  <= bit_cnt + BC_W'(1);
                    // raise valid together with the done pulse
                    if (bit_last) resp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_array_seq.sv
// Directed bench for puf_array_seq: load, run latency, voting, reset gating,
// select errors, zero settle and asynchronous abort.
module tb_puf_array_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        si;
    logic        si_en;
    logic        so;
    logic        start;
    logic [2:0]  puf_sel;
    logic [1:0]  length_in;
    logic [7:0]  settle;
    logic [15:0] chal;
    logic [1:0]  length;
    logic [3:0]  puf_reset;
    logic [3:0]  puf_out;
    logic        busy;
    logic        done;
    logic [3:0]  resp;
    logic        resp_valid;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    puf_array_seq #(
        .N_PUF(4), .SEL_W(3), .CHAL_BITS(16), .RESP_BITS(4), .VOTES(3), .RST_CYC(2)
    ) dut (
        .clk(clk), .rstn(rstn), .si(si), .si_en(si_en), .so(so), .start(start),
        .puf_sel(puf_sel), .length_in(length_in), .settle(settle), .chal(chal),
        .length(length), .puf_reset(puf_reset), .puf_out(puf_out), .busy(busy),
        .done(done), .resp(resp), .resp_valid(resp_valid), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [2:0] sel, input logic [7:0] st, input logic [1:0] len);
        puf_sel   = sel;
        settle    = st;
        length_in = len;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int bound, output int c);
        c = c0;
        while (done !== 1'b1 && c < bound) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; si = 0; si_en = 0; start = 0; puf_sel = 0;
        length_in = 0; settle = 0; puf_out = 0;
        repeat (2) @(negedge clk);
        checks++; if (puf_reset !== 4'hF) begin errors++; $display("FAIL reset_puf_reset got %h exp f", puf_reset); end
        checks++; if (chal !== 16'h0) begin errors++; $display("FAIL reset_chal got %h exp 0", chal); end
        checks++; if ({busy, done, resp_valid, sel_err, so} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 00000", {busy, done, resp_valid, sel_err, so}); end
        checks++; if ({resp, length} !== 6'b0) begin errors++; $display("FAIL reset_resp_len got %h exp 0", {resp, length}); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        logic [15:0] pat;
        pat = 16'hA5C3;
        for (int i = 15; i >= 0; i--) begin
            si = pat[i]; si_en = 1'b1;
            @(negedge clk);
        end
        si_en = 1'b0; si = 1'b0;
        checks++; if (chal !== 16'hA5C3) begin errors++; $display("FAIL load_chal got %h exp a5c3", chal); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL load_so got %b exp 1", so); end
    endtask

    task automatic test_run;
        int c;
        puf_out = 4'b0100;
        do_start(3'd2, 8'd3, 2'b10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b exp 1", busy); end
        checks++; if (length !== 2'b10) begin errors++; $display("FAIL run_length got %b exp 10", length); end
        puf_sel = 3'd0; settle = 8'd1; length_in = 2'b01; si_en = 1'b1; si = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (chal !== 16'hA5C3) begin errors++; $display("FAIL run_chal_hold got %h exp a5c3", chal); end
        wait_done(5, 200, c);
        si_en = 1'b0; si = 1'b0;
        checks++; if (c !== 77) begin errors++; $display("FAIL run_latency got %0d exp 77", c); end
        checks++; if (resp !== 4'hF) begin errors++; $display("FAIL run_resp got %h exp f", resp); end
        checks++; if (length !== 2'b10) begin errors++; $display("FAIL run_length_end got %b exp 10", length); end
        @(negedge clk);
        checks++; if ({done, busy, resp_valid} !== 3'b001) begin errors++;
            $display("FAIL run_after got %b exp 001", {done, busy, resp_valid}); end
        checks++; if (chal !== 16'h5C3A) begin errors++; $display("FAIL run_chal_rot got %h exp 5c3a", chal); end
    endtask

    task automatic test_vote;
        int pat [12] = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        int tmo;
        int c;
        tmo = 0;
        puf_out = 4'b0000;
        do_start(3'd1, 8'd3, 2'b00);
        for (int v = 0; v < 12; v++) begin
            c = 0;
            while (puf_reset[1] !== 1'b0 && c < 20) begin @(negedge clk); c++; end
            if (c >= 20) tmo++;
            puf_out[1] = pat[v][0];
            c = 0;
            while (puf_reset[1] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
            if (c >= 20) tmo++;
        end
        checks++; if (tmo !== 0) begin errors++; $display("FAIL vote_timeouts got %0d exp 0", tmo); end
        wait_done(0, 20, c);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL vote_done got %b exp 1", done); end
        checks++; if (resp !== 4'b1000) begin errors++; $display("FAIL vote_resp got %b exp 1000", resp); end
        @(negedge clk);
        checks++; if (chal !== 16'hC3A5) begin errors++; $display("FAIL vote_chal got %h exp c3a5", chal); end
    endtask

    task automatic test_gating;
        int c;
        int bad;
        int zeros;
        logic [6:0] seq;
        bad = 0; zeros = 0; seq = '0;
        puf_out = 4'hF;
        do_start(3'd3, 8'd3, 2'b00);
        c = 1;
        while (done !== 1'b1 && c < 200) begin
            if (puf_reset[2:0] !== 3'b111) bad++;
            if (c <= 7) seq = {seq[5:0], puf_reset[3]};
            if (puf_reset[3] === 1'b0) zeros++;
            @(negedge clk);
            c++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gate_others got %0d bad cycles exp 0", bad); end
        checks++; if (seq !== 7'b1100001) begin errors++; $display("FAIL gate_first_vote got %b exp 1100001", seq); end
        checks++; if (zeros !== 48) begin errors++; $display("FAIL gate_release_cycles got %0d exp 48", zeros); end
        checks++; if (c !== 77) begin errors++; $display("FAIL gate_latency got %0d exp 77", c); end
        checks++; if (resp !== 4'hF) begin errors++; $display("FAIL gate_resp got %h exp f", resp); end
        @(negedge clk);
    endtask

    task automatic test_errors;
        int c;
        do_start(3'd5, 8'd3, 2'b11);
        checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", sel_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", busy); end
        checks++; if ({resp_valid, resp, length} !== 7'b1111100) begin errors++;
            $display("FAIL err_outputs got %b exp 1111100", {resp_valid, resp, length}); end
        checks++; if (puf_reset !== 4'hF) begin errors++; $display("FAIL err_puf_reset got %h exp f", puf_reset); end
        do_start(3'd0, 8'd0, 2'b00);
        checks++; if ({sel_err, busy, resp_valid} !== 3'b010) begin errors++;
            $display("FAIL err_clear got %b exp 010", {sel_err, busy, resp_valid}); end
        checks++; if (resp !== 4'h0) begin errors++; $display("FAIL err_resp_clear got %h exp 0", resp); end
        wait_done(1, 200, c);
        checks++; if (c !== 53) begin errors++; $display("FAIL settle0_latency got %0d exp 53", c); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        puf_out = 4'hF;
        do_start(3'd2, 8'd0, 2'b01);
        repeat (19) @(negedge clk);
        checks++; if (resp !== 4'b0001) begin errors++; $display("FAIL abort_pre_resp got %b exp 0001", resp); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (puf_reset !== 4'hF) begin errors++; $display("FAIL abort_puf_reset got %h exp f", puf_reset); end
        checks++; if ({busy, resp_valid, length} !== 4'b0) begin errors++;
            $display("FAIL abort_flags got %b exp 0000", {busy, resp_valid, length}); end
        checks++; if (resp !== 4'h0) begin errors++; $display("FAIL abort_resp got %h exp 0", resp); end
        checks++; if (chal !== 16'h0) begin errors++; $display("FAIL abort_chal got %h exp 0", chal); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_vote();
        test_gating();
        test_errors();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
